// File: rtl/eth_tx_mac.sv
// Byte-wide Ethernet transmit MAC: preamble/SFD, zero padding to the minimum frame,
// CRC-32 FCS and inter-frame gap, driving a GMII-style transmit port.
//
// state | meaning
// IDLE  | no frame in progress, waiting for eth_tx_data_en
// PRE   | 0x55 preamble bytes; ack issued with the last one
// SFD   | 0xD5 start-of-frame delimiter
// DATA  | upstream bytes passed through and folded into the CRC
// PAD   | 0x00 fill until the minimum frame length is reached
// FCS   | complemented CRC, least-significant byte first
// IFG   | transmitter idle for the gap, tx_busy still high
module eth_tx_mac #(
    parameter int MIN_FRAME = 60,
    parameter int MAX_FRAME = 9014,
    parameter int IFG_BYTES = 12
) (
    input  logic       eth_tx_clk,
    input  logic       eth_tx_rst_n,
    input  logic [7:0] eth_tx_data,
    input  logic       eth_tx_data_en,
    output logic       eth_tx_ack,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_busy,
    output logic       tx_frame_done
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    localparam logic [15:0] MIN_N = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_N = 16'(MAX_FRAME);
    localparam logic [15:0] IFG_N = 16'(IFG_BYTES);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [15:0] n, n_nx;
    logic [31:0] crc, crc_nx;
    logic        ovf, ovf_nx;
    logic        drop, drop_nx;
    logic [7:0]  txd_nx;
    logic        en_nx, er_nx, ack_nx, busy_nx, done_nx;
    logic        do_start, do_load, do_end;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        n_nx     = n;
        crc_nx   = crc;
        ovf_nx   = ovf;
        drop_nx  = drop;
        txd_nx   = 8'h00;
        en_nx    = 1'b0;
        er_nx    = 1'b0;
        ack_nx   = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        do_start = 1'b0;
        do_load  = 1'b0;
        do_end   = 1'b0;

        case (state)
            IDLE: do_start = eth_tx_data_en;
            PRE: begin
                busy_nx = 1'b1;
                if (cnt == 16'd0) begin
                    // a request dropped during the ack cycle still gets a padded frame
                    state_nx = SFD;
                    txd_nx   = 8'hD5;
                    en_nx    = 1'b1;
                    drop_nx  = ~eth_tx_data_en;
                end else if (!eth_tx_data_en) begin
                    state_nx = IFG;
                    er_nx    = 1'b1;
                    cnt_nx   = IFG_N;
                end else begin
                    txd_nx = 8'h55;
                    en_nx  = 1'b1;
                    ack_nx = (cnt == 16'd1);
                    cnt_nx = cnt - 16'd1;
                end
            end
            SFD: begin
                do_load = eth_tx_data_en & ~drop;
                do_end  = ~do_load;
            end
            DATA: begin
                do_load = eth_tx_data_en;
                do_end  = ~eth_tx_data_en;
            end
            PAD: do_end = 1'b1;
            FCS: begin
                busy_nx = 1'b1;
                if (cnt == 16'd0) begin
                    state_nx = IFG;
                    cnt_nx   = IFG_N - 16'd1;
                end else begin
                    txd_nx  = ~crc[7:0];
                    crc_nx  = crc >> 8;
                    en_nx   = 1'b1;
                    er_nx   = ovf;
                    done_nx = (cnt == 16'd1);
                    cnt_nx  = cnt - 16'd1;
                end
            end
            IFG: begin
                busy_nx = 1'b1;
                if (cnt == 16'd0) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    do_start = eth_tx_data_en;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (do_start) begin
            state_nx = PRE;
            cnt_nx   = 16'd6;
            n_nx     = 16'd0;
            crc_nx   = 32'hFFFFFFFF;
            ovf_nx   = 1'b0;
            drop_nx  = 1'b0;
            txd_nx   = 8'h55;
            en_nx    = 1'b1;
            busy_nx  = 1'b1;
        end

        if (do_load) begin
            state_nx = DATA;
            txd_nx   = eth_tx_data;
            en_nx    = 1'b1;
            busy_nx  = 1'b1;
            crc_nx   = crc_upd(crc, eth_tx_data);
            n_nx     = (n == 16'hFFFF) ? n : n + 16'd1;
            ovf_nx   = ovf | (n >= MAX_N);
            er_nx    = ovf_nx;
        end

        if (do_end) begin
            en_nx   = 1'b1;
            busy_nx = 1'b1;
            er_nx   = ovf;
            if (n < MIN_N) begin
                state_nx = PAD;
                txd_nx   = 8'h00;
                crc_nx   = crc_upd(crc, 8'h00);
                n_nx     = n + 16'd1;
            end else begin
                state_nx = FCS;
                txd_nx   = ~crc[7:0];
                crc_nx   = crc >> 8;
                cnt_nx   = 16'd3;
            end
        end
    end

    always_ff @(posedge eth_tx_clk) begin
        if (!eth_tx_rst_n) begin
            state         <= IDLE;
            cnt           <= 16'd0;
            n             <= 16'd0;
            crc           <= 32'hFFFFFFFF;
            ovf           <= 1'b0;
            drop          <= 1'b0;
            gmii_txd      <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
            eth_tx_ack    <= 1'b0;
            tx_busy       <= 1'b0;
            tx_frame_done <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            n             <= n_nx;
            crc           <= crc_nx;
            ovf           <= ovf_nx;
            drop          <= drop_nx;
            gmii_txd      <= txd_nx;
            gmii_tx_en    <= en_nx;
            gmii_tx_er    <= er_nx;
            eth_tx_ack    <= ack_nx;
            tx_busy       <= busy_nx;
            tx_frame_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_eth_tx_mac.sv
// Self-checking bench for eth_tx_mac: a per-cycle expected-output table built from
// the frame format, compared against the DUT on every falling edge.
module tb_eth_tx_mac;

    localparam int MIN_FRAME = 60;
    localparam int MAX_FRAME = 9014;
    localparam int IFG_BYTES = 12;

    logic       eth_tx_clk = 1'b0;
    logic       eth_tx_rst_n = 1'b0;
    logic [7:0] eth_tx_data = 8'h00;
    logic       eth_tx_data_en = 1'b0;
    logic       eth_tx_ack;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, tx_busy, tx_frame_done;

    eth_tx_mac #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .IFG_BYTES(IFG_BYTES)) dut (
        .eth_tx_clk    (eth_tx_clk),
        .eth_tx_rst_n  (eth_tx_rst_n),
        .eth_tx_data   (eth_tx_data),
        .eth_tx_data_en(eth_tx_data_en),
        .eth_tx_ack    (eth_tx_ack),
        .gmii_txd      (gmii_txd),
        .gmii_tx_en    (gmii_tx_en),
        .gmii_tx_er    (gmii_tx_er),
        .tx_busy       (tx_busy),
        .tx_frame_done (tx_frame_done)
    );

    always #5 eth_tx_clk = ~eth_tx_clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int idle_from = 0;
    logic [12:0] exp_tab [int];   // {txd, en, er, ack, busy, done} per rising edge
    logic [7:0]  pl [$];

    int run = 0, low = 0, pos = 0, last_run = 0, last_gap = 0, ack_cnt = 0;
    logic [31:0] res = 32'hFFFFFFFF;

    always @(posedge eth_tx_clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic logic [12:0] mk(input logic [7:0] d, input logic en, input logic er,
                                       input logic ack, input logic busy, input logic done);
        return {d, en, er, ack, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", name, got, got, want, want);
        end
    endtask

    // Expected timeline of a full frame whose request is first served at edge e.
    function automatic void sched_frame(input int e);
        logic [7:0]  fb [$];
        logic [31:0] c, fcs;
        int len, ndata;
        fb = pl;
        ndata = pl.size();
        while (fb.size() < MIN_FRAME) fb.push_back(8'h00);
        len = fb.size();
        c = 32'hFFFFFFFF;
        foreach (fb[i]) c = crc_step(c, fb[i]);
        fcs = ~c;
        for (int k = 0; k < 7; k++) exp_tab[e + k] = mk(8'h55, 1, 0, k == 6, 1, 0);
        exp_tab[e + 7] = mk(8'hD5, 1, 0, 0, 1, 0);
        for (int i = 0; i < len; i++) exp_tab[e + 8 + i] = mk(fb[i], 1, (i + 1) > MAX_FRAME, 0, 1, 0);
        for (int j = 0; j < 4; j++)
            exp_tab[e + 8 + len + j] = mk(8'(fcs >> (8 * j)), 1, ndata > MAX_FRAME, 0, 1, j == 3);
        for (int g = 0; g < IFG_BYTES; g++) exp_tab[e + 12 + len + g] = mk(8'h00, 0, 0, 0, 1, 0);
        idle_from = e + 12 + len + IFG_BYTES;
    endfunction

    always @(negedge eth_tx_clk) begin
        logic [12:0] want, got;
        want = exp_tab.exists(edge_cnt) ? exp_tab[edge_cnt] : 13'h0;
        got = {gmii_txd, gmii_tx_en, gmii_tx_er, eth_tx_ack, tx_busy, tx_frame_done};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL outputs at edge %0d: got txd=%02h en=%b er=%b ack=%b busy=%b done=%b, want txd=%02h en=%b er=%b ack=%b busy=%b done=%b",
                     edge_cnt, got[12:5], got[4], got[3], got[2], got[1], got[0],
                     want[12:5], want[4], want[3], want[2], want[1], want[0]);
        end
        if (eth_tx_ack) ack_cnt++;
        if (gmii_tx_en) begin
            if (run == 0) last_gap = low;
            run++;
            low = 0;
            if (pos >= 8) res = crc_step(res, gmii_txd);
            pos++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
            low++;
            pos = 0;
            res = 32'hFFFFFFFF;
        end
        if (tx_frame_done) begin
            checks++;
            if (res !== 32'hDEBB20E3) begin
                errors++;
                $display("FAIL crc_residue: got 0x%08h, want 0xDEBB20E3", res);
            end
        end
    end

    task automatic fill(input int len, input int kind);
        pl.delete();
        for (int i = 0; i < len; i++)
            pl.push_back(kind == 0 ? 8'(i) : 8'(i * 37 + 11));
    endtask

    // Called at a falling edge; rst_idx >= 0 asserts reset together with that data byte.
    task automatic send_frame(input int rst_idx);
        int  e, r;
        bit  got_ack;
        e = (edge_cnt + 1 > idle_from) ? edge_cnt + 1 : idle_from;
        sched_frame(e);
        ack_cnt = 0;
        eth_tx_data_en = 1'b1;
        got_ack = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge eth_tx_clk);
            if (eth_tx_ack) begin
                got_ack = 1;
                break;
            end
        end
        if (!got_ack) begin
            check("ack_timeout", 0, 1);
            eth_tx_data_en = 1'b0;
            return;
        end
        if (pl.size() == 0) begin
            eth_tx_data_en = 1'b0;
            return;
        end
        for (int i = 0; i < pl.size(); i++) begin
            @(negedge eth_tx_clk);
            eth_tx_data = pl[i];
            if (i == rst_idx) begin
                int keys [$];
                eth_tx_rst_n = 1'b0;
                r = edge_cnt + 1;
                foreach (exp_tab[k]) if (k >= r) keys.push_back(k);
                foreach (keys[j]) exp_tab.delete(keys[j]);
                idle_from = 0;
                @(negedge eth_tx_clk);
                eth_tx_data_en = 1'b0;
                @(negedge eth_tx_clk);
                @(negedge eth_tx_clk);
                eth_tx_rst_n = 1'b1;
                return;
            end
        end
        @(negedge eth_tx_clk);
        eth_tx_data_en = 1'b0;
        eth_tx_data = 8'h00;
    endtask

    task automatic wait_idle();
        while (edge_cnt < idle_from + 2) @(negedge eth_tx_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] c;
        logic [7:0]  s [9];
        int e, last_fcs;

        for (int i = 0; i < 9; i++) s[i] = 8'h31 + 8'(i);
        c = 32'hFFFFFFFF;
        foreach (s[i]) c = crc_step(c, s[i]);
        check("crc_check_string", ~c, 32'hCBF43926);

        repeat (4) @(negedge eth_tx_clk);
        eth_tx_rst_n = 1'b1;
        @(negedge eth_tx_clk);

        // 42-byte ARP reply: padded to 60
        fill(42, 1);
        send_frame(-1);
        wait_idle();
        check("arp_en_cycles", last_run, 72);
        check("arp_ack_count", ack_cnt, 1);

        // 1500-byte incrementing frame
        fill(1500, 0);
        send_frame(-1);
        wait_idle();
        check("f1500_en_cycles", last_run, 1512);

        // back-to-back: second request rises 2 cycles after the last FCS byte
        fill(46, 1);
        send_frame(-1);
        last_fcs = idle_from - 1 - IFG_BYTES;
        while (edge_cnt < last_fcs + 1) @(negedge eth_tx_clk);
        fill(64, 0);
        send_frame(-1);
        check("b2b_gap", last_gap, 12);
        wait_idle();
        check("b2b_en_cycles", last_run, 76);
        check("b2b_ack_count", ack_cnt, 1);

        // request withdrawn at the 3rd preamble byte
        ack_cnt = 0;
        e = edge_cnt + 1;
        exp_tab[e]     = mk(8'h55, 1, 0, 0, 1, 0);
        exp_tab[e + 1] = mk(8'h55, 1, 0, 0, 1, 0);
        exp_tab[e + 2] = mk(8'h00, 0, 1, 0, 1, 0);
        for (int g = 0; g < IFG_BYTES; g++) exp_tab[e + 3 + g] = mk(8'h00, 0, 0, 0, 1, 0);
        idle_from = e + 3 + IFG_BYTES;
        eth_tx_data_en = 1'b1;
        @(negedge eth_tx_clk);
        @(negedge eth_tx_clk);
        eth_tx_data_en = 1'b0;
        wait_idle();
        check("abort_en_cycles", last_run, 2);
        check("abort_ack_count", ack_cnt, 0);

        // oversize: 9020 bytes
        fill(9020, 0);
        send_frame(-1);
        wait_idle();
        check("oversize_en_cycles", last_run, 9032);

        // reset with DATA byte 20, then a clean 60-byte frame
        fill(60, 1);
        send_frame(19);
        @(negedge eth_tx_clk);
        check("reset_partial_en_cycles", last_run, 27);
        fill(60, 0);
        send_frame(-1);
        wait_idle();
        check("post_reset_en_cycles", last_run, 72);

        // request withdrawn in the ack cycle: empty frame, fully padded
        fill(0, 0);
        send_frame(-1);
        wait_idle();
        check("empty_en_cycles", last_run, 72);
        check("empty_ack_count", ack_cnt, 1);

        repeat (3) @(negedge eth_tx_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
